tpu_matmul_core: RTL and testbench
==================================

TPU_MATMUL_CORE -- requirements
Module: tpu_matmul_core

Interface
REQ-001 SHALL have parameter N, default 2, array dimension (legal 2..4).
REQ-002 SHALL have parameter DW, default 8, operand width (legal 4..16).
REQ-003 SHALL have parameter ACCW, default 18, accumulator/result width (legal >= 2*DW+2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  host operand strobe.
REQ-007 SHALL have port in_data  input  DW  operand element.
REQ-008 SHALL have port in_ready  output  1  high only in LOAD state.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands; sampled at LOAD->COMPUTE.
REQ-010 SHALL have port acc_mode  input  1  1 = add onto previous results; sampled at LOAD->COMPUTE.
REQ-011 SHALL have port abort  input  1  synchronous abort to LOAD.
REQ-012 SHALL have port out_data  output  ACCW  result element.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  host accepts result.
REQ-015 SHALL have port busy  output  1  high when state != LOAD.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of result stream.

Function
REQ-017 SHALL implement states LOAD, COMPUTE, OUTPUT; reset state LOAD.
REQ-018 SHALL accept an element when in_valid && in_ready; 2*N*N elements per job: first B (weights) row-major, then A (inputs) row-major.
REQ-019 SHALL ignore in_valid outside LOAD; SHALL discard nothing partial: a load counter advances only on handshake.
REQ-020 SHALL transition LOAD->COMPUTE on the edge accepting element 2*N*N-1, resetting the load counter to 0.
REQ-021 SHALL compute C = A x B, C[i][j] = sum_k A[i][k]*B[k][j], via an NxN output-stationary MAC grid with skewed operand feed.
REQ-022 SHALL stay in COMPUTE exactly 3N-2 cycles, then enter OUTPUT; out_valid first high exactly 3N-1 edges after the last load handshake (5 for N=2).
REQ-023 SHALL sign-extend operands to ACCW when signed_mode=1, zero-extend when 0; products and sums wrap modulo 2^ACCW.
REQ-024 SHALL clear all accumulators on LOAD->COMPUTE when acc_mode=0; keep them when acc_mode=1.
REQ-025 SHALL stream N*N results row-major (C[0][0] first); advance on out_valid && out_ready only.
REQ-026 SHALL hold out_data and out_valid stable while out_ready=0.
REQ-027 SHALL, on final output handshake, return to LOAD and pulse done for exactly the next cycle (done and in_ready rise together).
REQ-028 SHALL give abort priority over all events: next edge -> LOAD, counters 0, accumulators 0, out_valid 0, done 0.
REQ-029 SHALL hold operand storage across jobs but require a full reload each job.
REQ-030 SHALL sample signed_mode/acc_mode only at LOAD->COMPUTE; changes elsewhere have no effect.

Reset
REQ-031 SHALL, while rst_n=0, force state LOAD, counters 0, accumulators 0, out_data 0, out_valid 0, done 0, busy 0, in_ready 1, independent of clk.
REQ-032 SHALL resume normal operation on first rising edge after rst_n deasserts; reset mid-COMPUTE/OUTPUT discards the job.

Verification
REQ-033 Unsigned, N=2: B=[[1,2],[3,4]], A=[[5,6],[7,8]], acc_mode=0 -> out stream 23,34,31,46; first out_valid 5 edges after last load; done pulse 1 cycle.
REQ-034 Signed: A=[[0xFF,0],[0,0xFF]], B=[[2,3],[4,5]], signed_mode=1 -> 0x3FFFE,0x3FFFD,0x3FFFC,0x3FFFB; same bytes signed_mode=0 -> 510,765,1020,1275.
REQ-035 Accumulate: REQ-033 job, then repeat with acc_mode=1 -> 46,68,62,92.
REQ-036 Backpressure: out_ready=0 for 5 cycles at first out_valid -> out_data holds 23, no advance; stream completes 23,34,31,46.
REQ-037 Abort mid-COMPUTE, then REQ-033 job with acc_mode=1 -> in_ready high next edge; results 23,34,31,46 (accumulators cleared).
REQ-038 rst_n low mid-OUTPUT -> out_valid, busy 0 immediately without clock edge; in_ready 1.

Source files
------------

// File: rtl/tpu_matmul_core.sv
// tpu_matmul_core: NxN output-stationary systolic matrix multiplier.
// Loads B then A row-major, runs a skewed MAC wavefront, streams C row-major.
module tpu_matmul_core #(
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int ACCW = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    input  logic            signed_mode,
    input  logic            acc_mode,
    input  logic            abort,
    output logic [ACCW-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);
    localparam int NN       = N * N;
    localparam int NOPS     = 2 * NN;
    localparam int LW       = $clog2(NOPS);
    localparam int OW       = $clog2(NN);
    localparam int CMP_LAST = 3 * N - 3;
    localparam int CW       = $clog2(CMP_LAST + 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t          r_state, w_next_state;
    logic [LW-1:0]   r_ld_cnt;
    logic [CW-1:0]   r_cmp_cnt;
    logic [OW-1:0]   r_out_idx, w_next_idx;
    logic            r_out_valid, r_done, r_signed;
    logic [ACCW-1:0] r_out_data;
    logic [DW-1:0]   r_ops    [NOPS];
    logic [DW-1:0]   r_a_pipe [N][N];
    logic [DW-1:0]   r_b_pipe [N][N];
    logic [DW-1:0]   w_a_in   [N][N];
    logic [DW-1:0]   w_b_in   [N][N];
    logic [ACCW-1:0] r_acc    [NN];
    logic            w_ld_hs, w_ld_last, w_cmp_last, w_out_hs, w_out_last;

    function automatic logic [ACCW-1:0] ext_op(input logic [DW-1:0] v, input logic sgn);
        logic fill;
        fill = sgn & v[DW-1];
        return {{(ACCW-DW){fill}}, v};
    endfunction

    assign w_ld_hs    = in_valid && (r_state == ST_LOAD);
    assign w_ld_last  = w_ld_hs && (r_ld_cnt == LW'(NOPS - 1));
    assign w_cmp_last = (r_state == ST_COMPUTE) && (r_cmp_cnt == CW'(CMP_LAST));
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_out_last = w_out_hs && (r_out_idx == OW'(NN - 1));
    assign w_next_idx = r_out_idx + OW'(1);

    assign in_ready  = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_LOAD);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort overrides every transition
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:    w_next_state = w_ld_last  ? ST_COMPUTE : ST_LOAD;
                ST_COMPUTE: w_next_state = w_cmp_last ? ST_OUTPUT  : ST_COMPUTE;
                ST_OUTPUT:  w_next_state = w_out_last ? ST_LOAD    : ST_OUTPUT;
                default:    w_next_state = ST_LOAD;
            endcase
        end
    end

    // Skewed edge feed: row i of A and column j of B enter i (or j) cycles late
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_a_in[i][j] = '0;
                w_b_in[i][j] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                w_a_in[0 + i][0] |= (int'(r_cmp_cnt) == i + k) ? r_ops[NN + i * N + k] : '0;
                w_b_in[0][0 + i] |= (int'(r_cmp_cnt) == i + k) ? r_ops[k * N + i] : '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                w_a_in[i][j] = r_a_pipe[i][j-1];
                w_b_in[j][i] = r_b_pipe[j-1][i];
            end
        end
    end

    // Operand storage persists across jobs and is rewritten on every load
    always_ff @(posedge clk) begin
        if (w_ld_hs && !abort) begin
            r_ops[r_ld_cnt] <= in_data;
        end
    end

    // Load/compute/output datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt    <= '0;
            r_cmp_cnt   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
            r_signed    <= 1'b0;
            for (int p = 0; p < NN; p++) r_acc[p] <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a_pipe[i][j] <= '0;
                    r_b_pipe[i][j] <= '0;
                end
            end
        end else if (abort) begin
            r_ld_cnt    <= '0;
            r_cmp_cnt   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            for (int p = 0; p < NN; p++) r_acc[p] <= '0;
        end else begin
            r_done <= w_out_last;
            case (r_state)
                ST_LOAD: begin
                    if (w_ld_last) begin
                        r_ld_cnt  <= '0;
                        r_cmp_cnt <= '0;
                        r_signed  <= signed_mode;
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                r_a_pipe[i][j] <= '0;
                                r_b_pipe[i][j] <= '0;
                            end
                        end
                        if (!acc_mode) begin
                            for (int p = 0; p < NN; p++) r_acc[p] <= '0;
                        end
                    end else if (w_ld_hs) begin
                        r_ld_cnt <= r_ld_cnt + LW'(1);
                    end
                end
                ST_COMPUTE: begin
                    r_cmp_cnt <= w_cmp_last ? '0 : r_cmp_cnt + CW'(1);
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_a_pipe[i][j] <= w_a_in[i][j];
                            r_b_pipe[i][j] <= w_b_in[i][j];
                            r_acc[i * N + j] <= r_acc[i * N + j]
                                + ext_op(w_a_in[i][j], r_signed) * ext_op(w_b_in[i][j], r_signed);
                        end
                    end
                end
                ST_OUTPUT: begin
                    // First OUTPUT cycle presents C[0][0] once the last MAC has settled
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_idx   <= '0;
                        r_out_data  <= r_acc[0];
                    end else if (w_out_last) begin
                        r_out_valid <= 1'b0;
                        r_out_idx   <= '0;
                    end else if (w_out_hs) begin
                        r_out_idx  <= w_next_idx;
                        r_out_data <= r_acc[w_next_idx];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_matmul_core.sv
// Scoreboard bench for tpu_matmul_core: plain-arithmetic matrix model feeds a
// queue of expected results, an independent monitor checks each output handshake.
module tb_tpu_matmul_core;
    localparam int N    = 2;
    localparam int DW   = 8;
    localparam int ACCW = 18;
    localparam int NN   = N * N;

    logic            clk = 1'b0;
    logic            rst_n, in_valid, in_ready, signed_mode, acc_mode, abort;
    logic            out_valid, out_ready, busy, done;
    logic [DW-1:0]   in_data;
    logic [ACCW-1:0] out_data;

    int              checks = 0;
    int              errors = 0;
    logic [ACCW-1:0] sb[$];
    longint          model_acc[NN];
    logic [DW-1:0]   ma[NN];
    logic [DW-1:0]   mb[NN];
    logic            prev_stall = 1'b0;
    logic [ACCW-1:0] prev_data  = '0;

    tpu_matmul_core #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .signed_mode(signed_mode), .acc_mode(acc_mode),
        .abort(abort), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every output handshake and checks hold under backpressure
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got %0d expected nothing", out_data);
                end else begin
                    chk("result", out_data, sb.pop_front());
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    function automatic longint sval(input logic [DW-1:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    // Reference model: C = (acc ? C : 0) + A x B, modulo 2^ACCW
    task automatic expect_job(input bit sgn, input bit accm);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                logic [ACCW-1:0] r;
                s = accm ? model_acc[i*N+j] : 0;
                for (int k = 0; k < N; k++) s += sval(ma[i*N+k], sgn) * sval(mb[k*N+j], sgn);
                r = s[ACCW-1:0];
                model_acc[i*N+j] = longint'(r);
                sb.push_back(r);
            end
        end
    endtask

    task automatic load_job(input bit sgn, input bit accm);
        signed_mode = sgn;
        acc_mode    = accm;
        for (int e = 0; e < 2 * NN; e++) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #2;
            end
            in_valid = 1'b1;
            in_data  = (e < NN) ? mb[e] : ma[e-NN];
            @(posedge clk); #2;
        end
        in_valid    = 1'b0;
        signed_mode = 1'($urandom);
        acc_mode    = 1'($urandom);
    endtask

    task automatic measure_latency();
        int lat = -1;
        for (int e = 1; e <= 3 * N + 6; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                chk("busy_compute", busy, 1);
                chk("in_ready_compute", in_ready, 0);
            end
            if (out_valid) begin
                lat = e;
                break;
            end
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
        end
        in_valid = 1'b0;
        chk("latency", lat, 3 * N - 1);
        #1;
    endtask

    task automatic wait_done(input bit bp);
        bit found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (done) begin
                found = 1'b1;
                chk("done_in_ready", in_ready, 1);
                chk("done_busy", busy, 0);
                @(posedge clk); #1;
                chk("done_width", done, 0);
                #1;
                break;
            end
            #1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
        out_ready = 1'b1;
    endtask

    task automatic run_job(input bit sgn, input bit accm, input bit bp);
        expect_job(sgn, accm);
        load_job(sgn, accm);
        measure_latency();
        wait_done(bp);
    endtask

    task automatic set_base();
        for (int p = 0; p < NN; p++) begin
            mb[p] = DW'(p + 1);
            ma[p] = DW'(p + 5);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; signed_mode = 1'b0;
        acc_mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
        for (int p = 0; p < NN; p++) model_acc[p] = 0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Basic unsigned job, then accumulate on top of it
        set_base();
        run_job(1'b0, 1'b0, 1'b0);
        run_job(1'b0, 1'b1, 1'b0);

        // Signed vs unsigned interpretation of the same bytes
        ma[0] = 8'hFF; ma[1] = 8'h00; ma[2] = 8'h00; ma[3] = 8'hFF;
        mb[0] = 8'd2;  mb[1] = 8'd3;  mb[2] = 8'd4;  mb[3] = 8'd5;
        run_job(1'b1, 1'b0, 1'b1);
        run_job(1'b0, 1'b0, 1'b1);

        // Backpressure held for five cycles on the first result
        set_base();
        expect_job(1'b0, 1'b0);
        out_ready = 1'b0;
        load_job(1'b0, 1'b0);
        measure_latency();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_23", out_data, 23);
            #1;
        end
        wait_done(1'b0);

        // Abort mid-compute clears accumulators
        load_job(1'b0, 1'b0);
        @(posedge clk); #2;
        abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        #1;
        abort = 1'b0;
        for (int p = 0; p < NN; p++) model_acc[p] = 0;
        run_job(1'b0, 1'b1, 1'b0);

        // Asynchronous reset while presenting results
        out_ready = 1'b0;
        load_job(1'b0, 1'b0);
        measure_latency();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_data", out_data, 0);
        chk("arst_done", done, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p < NN; p++) model_acc[p] = 0;
        run_job(1'b0, 1'b1, 1'b0);

        // Randomized jobs
        for (int t = 0; t < 10; t++) begin
            for (int p = 0; p < NN; p++) begin
                ma[p] = DW'($urandom);
                mb[p] = DW'($urandom);
            end
            run_job(1'($urandom), 1'($urandom), 1'($urandom));
        end

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
